// File: rtl/epl_fi_ctrl_sub.sv
// Fault-injection controller: holds word/bit masks, arms injection through a
// small config-write port, and counts the reads that were actually disturbed.
module epl_fi_ctrl_sub #(
    parameter int ADDR_WIDTH  = 5,
    parameter int WORD        = 32,
    parameter int TWORD_WIDTH = 16,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   pCLK_i,
    input  logic                   pRST_i,
    input  logic [ADDR_WIDTH-1:0]  pA_i,
    input  logic                   pREAD_i,
    input  logic                   pCfgWe_i,
    input  logic [1:0]             pCfgSel_i,
    input  logic [ADDR_WIDTH-1:0]  pCfgAddr_i,
    input  logic [TWORD_WIDTH-1:0] pCfgData_i,
    output logic                   pFIEN_o,
    output logic [WORD-1:0]        pFiWordMask_o,
    output logic [TWORD_WIDTH-1:0] pFiBitMask_o,
    output logic                   pFiDone_o,
    output logic [CNT_WIDTH-1:0]   pFiHitCnt_o
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_DONE = 2'd2} state_t;
    typedef enum logic [1:0] {M_OFF = 2'd0, M_ONESHOT = 2'd1, M_COUNT = 2'd2, M_CONT = 2'd3} mode_t;

    localparam logic [1:0] SEL_CTRL  = 2'd0;
    localparam logic [1:0] SEL_WMASK = 2'd1;
    localparam logic [1:0] SEL_BMASK = 2'd2;
    localparam logic [1:0] SEL_CLEAR = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                   state_q, state_d;
    mode_t                    mode_q, mode_d;
    logic                     rot_q, rot_d;
    logic [CNT_WIDTH-1:0]     remain_q, remain_d;
    logic [CNT_WIDTH-1:0]     hitcnt_q, hitcnt_d;
    logic [WORD-1:0]          wmask_q, wmask_d;
    logic [TWORD_WIDTH-1:0]   bmask_q, bmask_d;
    logic                     fien_q, done_q;
    logic                     hit;
    mode_t                    cfg_mode;
    logic [CNT_WIDTH-1:0]     cfg_n;

    // Same condition the downstream stage uses to disturb the read data.
    assign hit      = pREAD_i & fien_q & wmask_q[pA_i];
    assign cfg_mode = mode_t'(pCfgData_i[1:0]);
    assign cfg_n    = pCfgData_i[CNT_WIDTH+1:2];

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        rot_d    = rot_q;
        remain_d = remain_q;
        hitcnt_d = hitcnt_q;
        wmask_d  = wmask_q;
        bmask_d  = bmask_q;
        if (pCfgWe_i) begin
            case (pCfgSel_i)
                SEL_CTRL: begin
                    mode_d = cfg_mode;
                    rot_d  = pCfgData_i[CNT_WIDTH+2];
                    if (cfg_mode == M_OFF) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_ARMED;
                        hitcnt_d = '0;
                        remain_d = (cfg_mode == M_ONESHOT) ? CNT_ONE : cfg_n;
                        if (cfg_mode == M_COUNT && cfg_n == '0) state_d = ST_DONE;
                    end
                end
                SEL_WMASK: wmask_d[pCfgAddr_i] = pCfgData_i[0];
                SEL_BMASK: bmask_d = pCfgData_i;
                SEL_CLEAR: begin
                    wmask_d  = '0;
                    bmask_d  = '0;
                    hitcnt_d = '0;
                    state_d  = ST_IDLE;
                end
                default: ;
            endcase
        end else if (hit && state_q == ST_ARMED) begin
            if (hitcnt_q != CNT_MAX) hitcnt_d = hitcnt_q + CNT_ONE;
            if (rot_q) bmask_d = {bmask_q[TWORD_WIDTH-2:0], bmask_q[TWORD_WIDTH-1]};
            // ONESHOT is armed with remaining=1, so it shares the COUNT path.
            if (mode_q == M_ONESHOT || mode_q == M_COUNT) begin
                remain_d = remain_q - CNT_ONE;
                if (remain_q == CNT_ONE) state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge pCLK_i) begin
        if (pRST_i) begin
            state_q  <= ST_IDLE;
            mode_q   <= M_OFF;
            rot_q    <= 1'b0;
            remain_q <= '0;
            hitcnt_q <= '0;
            wmask_q  <= '0;
            bmask_q  <= '0;
            fien_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            rot_q    <= rot_d;
            remain_q <= remain_d;
            hitcnt_q <= hitcnt_d;
            wmask_q  <= wmask_d;
            bmask_q  <= bmask_d;
            fien_q   <= (state_d == ST_ARMED);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign pFIEN_o       = fien_q;
    assign pFiDone_o     = done_q;
    assign pFiHitCnt_o   = hitcnt_q;
    assign pFiWordMask_o = wmask_q;
    assign pFiBitMask_o  = bmask_q;

endmodule

// File: doc/epl_fi_ctrl_sub.md
# epl_fi_ctrl_sub

Fault-injection controller for the EPLFFRAM02 model. Holds the FI word mask and bit mask, arms and disarms injection under a small register-write interface, and counts injected reads. Sits directly upstream of the read-disturb injection stage: its `pFIEN_o`, `pFiWordMask_o` and `pFiBitMask_o` drive that stage's `pFIEN_i`, `pFiWordMask_i` and `pFiBitMask_i`. It observes the same `pA_i`/`pREAD_i` as that stage, so it knows exactly which reads were disturbed.

## Interface
Widths `ADDR_WIDTH`, `WORD` and `TWORD_WIDTH` come from `EPLFFRAM02_spec.vh`.
- CNT_WIDTH, 8, width of the shot count and the hit counter

Ports:
- pCLK_i  in  1  clock; all state updates on rising edge
- pRST_i  in  1  reset, synchronous, active-high
- pA_i  in  ADDR_WIDTH  macro read/write address
- pREAD_i  in  1  macro read strobe
- pCfgWe_i  in  1  config write enable
- pCfgSel_i  in  2  config target: 0=CTRL, 1=WMASK bit, 2=BMASK, 3=CLEAR
- pCfgAddr_i  in  ADDR_WIDTH  word index for WMASK writes
- pCfgData_i  in  TWORD_WIDTH  config data
- pFIEN_o  out  1  injection enable, registered
- pFiWordMask_o  out  WORD  per-word hit mask, registered
- pFiBitMask_o  out  TWORD_WIDTH  XOR pattern, registered
- pFiDone_o  out  1  shot budget exhausted
- pFiHitCnt_o  out  CNT_WIDTH  injected-read count, saturating

## Operation
- Hit: `hit = pREAD_i & pFIEN_o & pFiWordMask_o[pA_i]`. This is exactly the condition under which the downstream stage disturbs data.
- FSM states:
  - IDLE: `pFIEN_o`=0, `pFiDone_o`=0.
  - ARMED: `pFIEN_o`=1.
  - DONE: `pFIEN_o`=0, `pFiDone_o`=1.
- Config writes when `pCfgWe_i`=1:
  - CTRL (sel 0): `data[1:0]` is the mode (00 OFF, 01 ONESHOT, 10 COUNT, 11 CONT). `data[CNT_WIDTH+1:2]` is the shot count N. `data[CNT_WIDTH+2]` is ROT (walking-bit enable). Mode OFF goes to IDLE. Any other mode goes to ARMED, loads remaining=N (ONESHOT loads 1) and clears `pFiHitCnt_o`. COUNT with N=0 goes directly to DONE.
  - WMASK (sel 1): `mask[pCfgAddr_i] <= pCfgData_i[0]`; other bits unchanged. FSM unchanged.
  - BMASK (sel 2): bit mask <= `pCfgData_i`. FSM unchanged.
  - CLEAR (sel 3): word mask=0, bit mask=0, hit count=0, state goes to IDLE.
- On a hit in ARMED (no config write that cycle):
  - `pFiHitCnt_o` increments, saturating at all-ones.
  - If ROT=1, the bit mask rotates left by 1: MSB wraps to bit 0.
  - ONESHOT goes to DONE.
  - COUNT decrements remaining and goes to DONE when remaining reaches 0.
  - CONT stays in ARMED.
- DONE persists until a CTRL write or CLEAR. Reads in DONE are not counted.
- Simultaneous config write and hit: the write takes priority and the hit is not counted or acted on. Downstream injection still occurs that cycle, because `pFIEN_o` is already registered high.
- `pA_i` is not range-checked. `WORD` is a power of two, so any address indexes a valid mask bit.

## Timing
- Reset (pRST_i=1 at an edge) puts every output at 0: `pFIEN_o`=0, both masks 0, `pFiDone_o`=0, `pFiHitCnt_o`=0, state IDLE, ROT=0, remaining=0. Reset overrides a concurrent config write or hit.
- Reset mid-ARMED disarms at the next edge; outputs are 0 from the following cycle.
- Config write sampled at edge k is visible on the outputs in cycle k+1. There is no handshake: a write is accepted every cycle.
- The hit is evaluated combinationally in cycle c. Its FSM, counter and rotate effects are visible in cycle c+1.
- ONESHOT with back-to-back reads to a masked word: exactly one read (the first) sees `pFIEN_o`=1.
- COUNT N: exactly N masked reads are injected, then `pFIEN_o` falls in the cycle after the Nth.
- Unmasked reads and non-read cycles never change state.

## Test plan
- Reset then idle: all outputs 0. Reads to any address give hit=0 and `pFiHitCnt_o` stays 0.
- WMASK addr 5=1, BMASK=0x0001, CTRL ONESHOT, then 3 consecutive reads to addr 5: `pFIEN_o` is 1 for the first read only, `pFiHitCnt_o`=1, `pFiDone_o`=1 from the cycle after the first read.
- CTRL COUNT N=3 with reads alternating addr 5 (masked) and addr 6 (unmasked), 8 reads total: hit count goes 1,2,3, DONE follows the third addr-5 read, and addr-6 reads never count.
- CONT with ROT=1, BMASK=MSB-only, 2 hits: bit mask becomes 0x…01, then 0x…02. State stays ARMED and `pFiHitCnt_o`=2.
- Config write coinciding with a masked read in ARMED: the write takes effect and the hit is not counted. Separately, COUNT N=0 gives DONE next cycle with `pFIEN_o` never asserted.
- Saturation and reset mid-operation: CONT with 2^CNT_WIDTH+3 hits leaves `pFiHitCnt_o` at all-ones. Assert pRST_i mid-stream: all outputs are 0 the next cycle.
